// File: rtl/armleocpu_tlb_pkg.sv
// rtl/armleocpu_tlb_pkg.sv - shared widths, metadata bit indices and types for the TLB
package armleocpu_tlb_pkg;

  localparam int VPN_W  = 20;
  localparam int PPN_W  = 22;
  localparam int META_W = 8;

  localparam int META_V = 0;
  localparam int META_R = 1;
  localparam int META_W_BIT = 2;
  localparam int META_X = 3;
  localparam int META_U = 4;
  localparam int META_G = 5;
  localparam int META_A = 6;
  localparam int META_D = 7;

  typedef enum logic {
    ST_IDLE,
    ST_WALK
  } tlb_state_t;

  typedef struct packed {
    logic [PPN_W-1:0]  ppn;
    logic [META_W-1:0] meta;
  } tlb_data_t;

endpackage

// File: rtl/armleocpu_tlb_way.sv
// rtl/armleocpu_tlb_way.sv - one TLB entry: storage, valid bit and VPN match
module armleocpu_tlb_way
  import armleocpu_tlb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             write_en,
  input  logic [VPN_W-1:0] write_vpn,
  input  tlb_data_t        write_data,
  input  logic [VPN_W-1:0] cmp_vpn,
  output logic             hit,
  output tlb_data_t        data
);

  logic             valid;
  logic [VPN_W-1:0] vpn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      vpn   <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (write_en) begin
      valid <= 1'b1;
      vpn   <= write_vpn;
      data  <= write_data;
    end
  end

  assign hit = valid && (vpn == cmp_vpn);

endmodule

// File: rtl/armleocpu_tlb.sv
// rtl/armleocpu_tlb.sv - fully-associative TLB in front of the page table walker
// Optional hit/miss counters are built when ARMLEOCPU_TLB_STATS_EN is defined.
module armleocpu_tlb
  import armleocpu_tlb_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lookup_valid,
  input  logic [VPN_W-1:0]  lookup_vpn,
  output logic              lookup_ready,
  input  logic              invalidate,
  output logic              lookup_done,
  output logic [PPN_W-1:0]  lookup_ppn,
  output logic [META_W-1:0] lookup_metadata,
  output logic              lookup_pagefault,
  output logic              lookup_accessfault,
  output logic              resolve_request,
  output logic [VPN_W-1:0]  virtual_address,
  input  logic              resolve_done,
  input  logic              resolve_pagefault,
  input  logic              resolve_accessfault,
  input  logic [META_W-1:0] resolve_metadata,
  input  logic [PPN_W-1:0]  resolve_physical_address
`ifdef ARMLEOCPU_TLB_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int ENTRIES_W = $clog2(ENTRIES);

  tlb_state_t           state;
  logic [ENTRIES_W-1:0] ptr;
  logic                 invalidate_pending;
  logic [ENTRIES-1:0]   hit_vec;
  tlb_data_t            way_data [ENTRIES];
  tlb_data_t            hit_data;
  logic                 any_hit;
  logic                 accept;
  logic                 walk_end;
  logic                 refill;
  logic                 clear_all;

  // Scan downwards so the lowest matching index ends up selected.
  always_comb begin
    any_hit  = 1'b0;
    hit_data = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        any_hit  = 1'b1;
        hit_data = way_data[i];
      end
    end
  end

  assign lookup_ready = (state == ST_IDLE) && !invalidate;
  assign accept       = lookup_valid && lookup_ready;
  assign walk_end     = (state == ST_WALK) && resolve_done;
  assign refill       = walk_end && !resolve_pagefault && !resolve_accessfault
                        && !invalidate_pending && !invalidate;
  assign clear_all    = ((state == ST_IDLE) && invalidate)
                        || (walk_end && (invalidate_pending || invalidate));

  for (genvar g = 0; g < ENTRIES; g++) begin : g_way
    armleocpu_tlb_way u_way (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear_all),
      .write_en   (refill && (ptr == ENTRIES_W'(g))),
      .write_vpn  (virtual_address),
      .write_data ('{ppn: resolve_physical_address, meta: resolve_metadata}),
      .cmp_vpn    (lookup_vpn),
      .hit        (hit_vec[g]),
      .data       (way_data[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      ptr                <= '0;
      invalidate_pending <= 1'b0;
      lookup_done        <= 1'b0;
      lookup_ppn         <= '0;
      lookup_metadata    <= '0;
      lookup_pagefault   <= 1'b0;
      lookup_accessfault <= 1'b0;
      resolve_request    <= 1'b0;
      virtual_address    <= '0;
    end else begin
      lookup_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (any_hit) begin
              lookup_done        <= 1'b1;
              lookup_ppn         <= hit_data.ppn;
              lookup_metadata    <= hit_data.meta;
              lookup_pagefault   <= 1'b0;
              lookup_accessfault <= 1'b0;
            end else begin
              virtual_address <= lookup_vpn;
              resolve_request <= 1'b1;
              state           <= ST_WALK;
            end
          end
        end
        ST_WALK: begin
          if (invalidate)
            invalidate_pending <= 1'b1;
          if (resolve_done) begin
            resolve_request    <= 1'b0;
            lookup_done        <= 1'b1;
            lookup_ppn         <= resolve_physical_address;
            lookup_metadata    <= resolve_metadata;
            lookup_pagefault   <= resolve_pagefault;
            lookup_accessfault <= resolve_accessfault;
            invalidate_pending <= 1'b0;
            state              <= ST_IDLE;
            if (refill)
              ptr <= ptr + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ARMLEOCPU_TLB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (accept) begin
      if (any_hit)
        stat_hits <= stat_hits + 32'd1;
      else
        stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_armleocpu_tlb.sv
// tb/tb_armleocpu_tlb.sv - scoreboard bench for armleocpu_tlb with a PTW responder model
module tb_armleocpu_tlb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lookup_valid;
  logic [19:0] lookup_vpn;
  logic        lookup_ready;
  logic        invalidate;
  logic        lookup_done;
  logic [21:0] lookup_ppn;
  logic [7:0]  lookup_metadata;
  logic        lookup_pagefault;
  logic        lookup_accessfault;
  logic        resolve_request;
  logic [19:0] virtual_address;
  logic        resolve_done;
  logic        resolve_pagefault;
  logic        resolve_accessfault;
  logic [7:0]  resolve_metadata;
  logic [21:0] resolve_physical_address;
`ifdef ARMLEOCPU_TLB_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  always #5 clk = ~clk;

  armleocpu_tlb #(.ENTRIES(8)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .lookup_valid             (lookup_valid),
    .lookup_vpn               (lookup_vpn),
    .lookup_ready             (lookup_ready),
    .invalidate               (invalidate),
    .lookup_done              (lookup_done),
    .lookup_ppn               (lookup_ppn),
    .lookup_metadata          (lookup_metadata),
    .lookup_pagefault         (lookup_pagefault),
    .lookup_accessfault       (lookup_accessfault),
    .resolve_request          (resolve_request),
    .virtual_address          (virtual_address),
    .resolve_done             (resolve_done),
    .resolve_pagefault        (resolve_pagefault),
    .resolve_accessfault      (resolve_accessfault),
    .resolve_metadata         (resolve_metadata),
    .resolve_physical_address (resolve_physical_address)
`ifdef ARMLEOCPU_TLB_STATS_EN
    ,
    .stat_hits                (stat_hits),
    .stat_misses              (stat_misses)
`endif
  );

  typedef struct {
    logic [21:0] ppn;
    logic [7:0]  meta;
    logic        pf;
    logic        af;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  int          walk_cnt = 0;
  logic [21:0] ptw_ppn;
  logic [7:0]  ptw_meta;
  logic        ptw_pf;
  logic        ptw_af;
  int          ptw_delay = 5;
  logic [19:0] exp_va;
  bit          ptw_abort = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [21:0] pp(input logic [19:0] v);
    return {2'b10, v};
  endfunction

  always @(negedge clk) begin
    if (lookup_done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("done_ppn", lookup_ppn, e.ppn);
        check("done_meta", lookup_metadata, e.meta);
        check("done_pf", lookup_pagefault, e.pf);
        check("done_af", lookup_accessfault, e.af);
      end
    end
  end

  // PTW responder: answers each request ptw_delay cycles after seeing it.
  initial begin
    resolve_done = 1'b0;
    resolve_pagefault = 1'b0;
    resolve_accessfault = 1'b0;
    resolve_metadata = '0;
    resolve_physical_address = '0;
    forever begin
      @(negedge clk);
      if (resolve_request === 1'b1) begin
        walk_cnt++;
        check("walk_va", virtual_address, exp_va);
        for (int c = 1; c < ptw_delay; c++) begin
          @(negedge clk);
          if (!ptw_abort) check("req_held", {resolve_request, virtual_address}, {1'b1, exp_va});
        end
        resolve_done = 1'b1;
        resolve_physical_address = ptw_ppn;
        resolve_metadata = ptw_meta;
        resolve_pagefault = ptw_pf;
        resolve_accessfault = ptw_af;
        @(negedge clk);
        resolve_done = 1'b0;
        if (!ptw_abort) check("req_drop", resolve_request, 0);
      end
    end
  end

  task automatic lookup(input logic [19:0] vpn, input bit miss, input logic [21:0] ppn,
                        input logic [7:0] meta, input bit pf, input bit af, input int inv_at);
    exp_t e;
    int w0, d0, n;
    ptw_ppn = ppn; ptw_meta = meta; ptw_pf = pf; ptw_af = af; exp_va = vpn;
    e.ppn = ppn; e.meta = meta; e.pf = pf; e.af = af;
    sb.push_back(e);
    w0 = walk_cnt;
    d0 = done_cnt;
    @(negedge clk);
    lookup_valid = 1'b1;
    lookup_vpn = vpn;
    check("ready", lookup_ready, 1);
    @(posedge clk);
    #1 lookup_valid = 1'b0;
    @(negedge clk);
    #1;
    if (!miss) begin
      check("hit_latency", done_cnt - d0, 1);
    end else begin
      check("miss_not_ready", lookup_ready, 0);
      n = 0;
      while (done_cnt == d0 && n < 60) begin
        if (n == inv_at) begin
          invalidate = 1'b1;
          @(negedge clk);
          #1 invalidate = 1'b0;
        end else begin
          @(negedge clk);
          #1;
        end
        n++;
      end
      check("miss_done", done_cnt - d0, 1);
    end
    check("walks", walk_cnt - w0, miss);
  endtask

  initial begin
    int d0, w0;
    rst_n = 1'b0;
    lookup_valid = 1'b0;
    lookup_vpn = '0;
    invalidate = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", lookup_ready, 1);
    check("rst_done", lookup_done, 0);
    check("rst_req", resolve_request, 0);
    check("rst_va", virtual_address, 0);
    check("rst_ppn", {lookup_ppn, lookup_metadata, lookup_pagefault, lookup_accessfault}, 0);
`ifdef ARMLEOCPU_TLB_STATS_EN
    check("rst_stats", {stat_hits, stat_misses}, 0);
`endif
    rst_n = 1'b1;

    lookup(20'h00400, 1, 22'h000400, 8'h0F, 0, 0, -1);
    lookup(20'h00400, 0, 22'h000400, 8'h0F, 0, 0, -1);

    lookup(20'h00800, 1, pp(20'h00800), 8'h00, 0, 1, -1);
    lookup(20'h00800, 1, pp(20'h00800), 8'h00, 0, 1, -1);
    lookup(20'h00800, 1, pp(20'h00800), 8'h00, 1, 0, -1);
    lookup(20'h00800, 1, pp(20'h00800), 8'h00, 1, 0, -1);

    for (int v = 1; v <= 9; v++)
      lookup(20'(v), 1, pp(20'(v)), 8'hCF, 0, 0, -1);
    lookup(20'h00002, 0, pp(20'h00002), 8'hCF, 0, 0, -1);
    lookup(20'h00009, 0, pp(20'h00009), 8'hCF, 0, 0, -1);
    lookup(20'h00008, 0, pp(20'h00008), 8'hCF, 0, 0, -1);
    lookup(20'h00400, 1, 22'h000400, 8'h0F, 0, 0, -1);
    lookup(20'h00001, 1, pp(20'h00001), 8'hCF, 0, 0, -1);
    lookup(20'h00001, 0, pp(20'h00001), 8'hCF, 0, 0, -1);

    d0 = done_cnt;
    w0 = walk_cnt;
    @(negedge clk);
    invalidate = 1'b1;
    lookup_valid = 1'b1;
    lookup_vpn = 20'h00009;
    #1 check("inv_blocks_ready", lookup_ready, 0);
    @(negedge clk);
    invalidate = 1'b0;
    lookup_valid = 1'b0;
    #1 check("inv_no_accept", {done_cnt - d0, walk_cnt - w0}, 0);
    lookup(20'h00009, 1, pp(20'h00009), 8'hCF, 0, 0, -1);
    lookup(20'h00001, 1, pp(20'h00001), 8'hCF, 0, 0, -1);
    lookup(20'h00009, 0, pp(20'h00009), 8'hCF, 0, 0, -1);

    lookup(20'h00A00, 1, pp(20'h00A00), 8'hCF, 0, 0, 1);
    lookup(20'h00009, 1, pp(20'h00009), 8'hCF, 0, 0, -1);
    lookup(20'h00A00, 1, pp(20'h00A00), 8'hCF, 0, 0, -1);
    lookup(20'h00A00, 0, pp(20'h00A00), 8'hCF, 0, 0, -1);
    lookup(20'h00009, 0, pp(20'h00009), 8'hCF, 0, 0, -1);

    ptw_delay = 20;
    exp_va = 20'h00B00;
    d0 = done_cnt;
    @(negedge clk);
    lookup_valid = 1'b1;
    lookup_vpn = 20'h00B00;
    @(posedge clk);
    #1 lookup_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("req_before_rst", resolve_request, 1);
    ptw_abort = 1'b1;
    #1 rst_n = 1'b0;
    #1 check("req_async_drop", resolve_request, 0);
    check("done_in_rst", lookup_done, 0);
    repeat (25) @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_walk_no_done", done_cnt - d0, 0);
    check("ready_after_rst", lookup_ready, 1);
    ptw_abort = 1'b0;
    ptw_delay = 5;

    lookup(20'h00A00, 1, pp(20'h00A00), 8'hCF, 0, 0, -1);
    lookup(20'h00C00, 1, pp(20'h00C00), 8'hC7, 0, 0, -1);
    lookup(20'h00D00, 1, pp(20'h00D00), 8'hD3, 0, 0, -1);
    lookup(20'h00A00, 0, pp(20'h00A00), 8'hCF, 0, 0, -1);
    lookup(20'h00C00, 0, pp(20'h00C00), 8'hC7, 0, 0, -1);
    lookup(20'h00D00, 0, pp(20'h00D00), 8'hD3, 0, 0, -1);
    lookup(20'h00A00, 0, pp(20'h00A00), 8'hCF, 0, 0, -1);
    lookup(20'h00C00, 0, pp(20'h00C00), 8'hC7, 0, 0, -1);
`ifdef ARMLEOCPU_TLB_STATS_EN
    check("stat_misses", stat_misses, 3);
    check("stat_hits", stat_hits, 5);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
